// File: rtl/fan_ctrl_pkg.sv
// Shared constants and helpers for the fan tachometer measurement block.
// Holds the default parameter values, the startup sequencing state type used
// by the tach front end, and the width helper for the glitch-filter counter.
package fan_ctrl_pkg;

  localparam int unsigned DefCntWidth     = 16;
  localparam int unsigned DefWindowTicks  = 1000;
  localparam int unsigned DefFilterLen    = 4;
  localparam int unsigned DefStallWindows = 3;

  // Startup sequence of the tach front end: two cycles to fill the
  // synchronizer, one cycle to load the settled level, then normal running.
  typedef enum logic [1:0] {
    StFill0,
    StFill1,
    StLoad,
    StRun
  } prime_state_e;

  // Bits needed for a counter running 0 .. len-1, never less than 1.
  function automatic int unsigned filt_cnt_width(input int unsigned len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/fan_tach_filter.sv
// Tach front end: 2-flop synchronizer, optional glitch filter and rising-edge
// detector producing a registered one-cycle pulse per qualified rising edge.
//
// Build option: define FAN_TACH_GLITCH_FILTER_EN to enable the glitch filter.
// Without it the qualified level is the synchronized input and FILTER_LEN is
// unused.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_tach       asynchronous tach input
//   o_tach_pulse one-cycle strobe per qualified rising edge
module fan_tach_filter
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DefFilterLen
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tach,
  output logic o_tach_pulse
);

  if (FILTER_LEN < 2) begin : gen_filter_len_check
    $error("FILTER_LEN must be at least 2");
  end

  logic         sync1_q;
  logic         sync2_q;
  logic         qual;
  logic         prev_q;
  logic         pulse_q;
  prime_state_e state_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_tach;
      sync2_q <= sync1_q;
    end
  end

`ifdef FAN_TACH_GLITCH_FILTER_EN
  localparam int unsigned FiltW = filt_cnt_width(FILTER_LEN);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

  logic             level_q;
  logic [FiltW-1:0] filt_cnt_q;

  // Level flips only once the synchronized input has disagreed with it for
  // FILTER_LEN consecutive cycles; any agreement restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level_q    <= 1'b0;
      filt_cnt_q <= '0;
    end else if (state_q != StRun) begin
      level_q    <= sync2_q;
      filt_cnt_q <= '0;
    end else if (sync2_q == level_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FiltLast) begin
      level_q    <= sync2_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign qual = level_q;
`else
  assign qual = sync2_q;
`endif

  // Until the synchronizer holds a real sample the edge detector just tracks
  // the level, so a tach that is already high at reset release never pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StFill0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      case (state_q)
        StFill0: state_q <= StFill1;
        StFill1: state_q <= StLoad;
        StLoad:  state_q <= StRun;
        default: state_q <= StRun;
      endcase
      if (state_q == StRun) begin
        pulse_q <= qual & ~prev_q;
        prev_q  <= qual;
      end else begin
        pulse_q <= 1'b0;
        prev_q  <= sync2_q;
      end
    end
  end

  assign o_tach_pulse = pulse_q;

endmodule

// File: rtl/fan_tach_meas.sv
// Fan tachometer measurement: counts qualified tach edges over a window of
// i_tick strobes, publishes the count at each window close and flags a stall
// after STALL_WINDOWS consecutive empty windows.
//
// Build option: FAN_TACH_GLITCH_FILTER_EN enables the glitch filter in the
// tach front end (see fan_tach_filter).
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_tick       one-cycle time-base strobe
//   i_tach       asynchronous tach input
//   o_tach_pulse one-cycle strobe per qualified tach rising edge
//   o_clr_cnt    one-cycle strobe the cycle after window close
//   o_tach_cnt   edge count of the last completed window (saturating)
//   o_cnt_valid  high once a window has completed
//   o_fan_stall  stall flag
module fan_tach_meas
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = DefCntWidth,
  parameter int unsigned WINDOW_TICKS  = DefWindowTicks,
  parameter int unsigned FILTER_LEN    = DefFilterLen,
  parameter int unsigned STALL_WINDOWS = DefStallWindows
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_tach,
  output logic                 o_tach_pulse,
  output logic                 o_clr_cnt,
  output logic [CNT_WIDTH-1:0] o_tach_cnt,
  output logic                 o_cnt_valid,
  output logic                 o_fan_stall
);

  localparam int unsigned WinW = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam int unsigned ZeroW = $clog2(STALL_WINDOWS + 1);
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_TICKS - 1);
  localparam logic [ZeroW-1:0] ZeroMax = ZeroW'(STALL_WINDOWS);
  localparam logic [CNT_WIDTH-1:0] AccMax = '1;

  logic                 pulse;
  logic                 close;
  logic [WinW-1:0]      win_q;
  logic [CNT_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] acc_inc;
  logic [ZeroW-1:0]     zero_q;
  logic                 clr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 valid_q;
  logic                 stall_q;

  fan_tach_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_tach       (i_tach),
    .o_tach_pulse (pulse)
  );

  assign close = i_tick && (win_q == WinLast);

  // Accumulator plus the current pulse, saturating; at close this is the
  // captured value so a pulse in the closing cycle lands in that window.
  always_comb begin
    acc_inc = acc_q;
    if (pulse && (acc_q != AccMax)) begin
      acc_inc = acc_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_q   <= '0;
      acc_q   <= '0;
      zero_q  <= '0;
      clr_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      clr_q <= close;
      if (i_tick) begin
        win_q <= close ? '0 : win_q + 1'b1;
      end
      if (close) begin
        acc_q   <= '0;
        cnt_q   <= acc_inc;
        valid_q <= 1'b1;
        if (acc_inc == '0) begin
          if (zero_q != ZeroMax) begin
            zero_q <= zero_q + 1'b1;
          end
          // Stall rises on the capture that takes the counter to its limit.
          if (zero_q >= ZeroMax - 1'b1) begin
            stall_q <= 1'b1;
          end
        end else begin
          zero_q  <= '0;
          stall_q <= 1'b0;
        end
      end else begin
        acc_q <= acc_inc;
      end
    end
  end

  assign o_tach_pulse = pulse;
  assign o_clr_cnt    = clr_q;
  assign o_tach_cnt   = cnt_q;
  assign o_cnt_valid  = valid_q;
  assign o_fan_stall  = stall_q;

endmodule

// File: doc/fan_tach_meas.md
FAN_TACH_MEAS -- requirements
Module: fan_tach_meas

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the tach edge count.
REQ-002 Parameter WINDOW_TICKS, default 1000: i_tick strobes per measurement window, minimum 1.
REQ-003 Parameter FILTER_LEN, default 4: stable cycles required by the glitch filter, minimum 2.
REQ-004 Parameter STALL_WINDOWS, default 3: consecutive zero-count windows that flag a stall, minimum 1.
REQ-005 i_clk  in  1  single block clock; all logic SHALL be clocked on its rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_tick  in  1  one-cycle time-base strobe.
REQ-008 i_tach  in  1  asynchronous fan tachometer input.
REQ-009 o_tach_pulse  out  1  one-cycle strobe per qualified tach rising edge; feeds the downstream fan counter's clock-enable.
REQ-010 o_clr_cnt  out  1  one-cycle strobe at window close; feeds the downstream fan counter's clear.
REQ-011 o_tach_cnt  out  CNT_WIDTH  edge count of the last completed window.
REQ-012 o_cnt_valid  out  1  high once the first window has completed.
REQ-013 o_fan_stall  out  1  stall flag.

Function
REQ-014 i_tach SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 o_tach_pulse SHALL be registered and high for exactly one cycle per rising edge of the qualified tach level.
REQ-016 An internal window counter SHALL increment on i_tick.
REQ-017 On the i_tick that brings the window counter to WINDOW_TICKS, the window closes: the window counter returns to 0, and on the next cycle o_clr_cnt=1 for one cycle, o_tach_cnt updates and o_cnt_valid=1.
REQ-018 An internal edge accumulator SHALL count o_tach_pulse and saturate at 2^CNT_WIDTH-1 with no wrap.
REQ-019 At window close, the captured value SHALL include a pulse coincident with the closing cycle; the accumulator then restarts at 0.
REQ-020 o_tach_cnt SHALL hold its value between window closes.
REQ-021 A zero-window counter SHALL increment on each window captured as 0, saturating at STALL_WINDOWS.
REQ-022 Any nonzero capture SHALL clear the zero-window counter and o_fan_stall in the same update.
REQ-023 o_fan_stall SHALL assert in the capture cycle in which the zero-window counter reaches STALL_WINDOWS.
REQ-024 i_tick held high SHALL count once per cycle; the window length is therefore measured in i_tick strobes, not in clocks.

Reset
REQ-025 While i_rst=1 at a clock edge: all outputs, the synchronizer, filter, window, accumulator and zero-window state SHALL clear to 0.
REQ-026 The synchronizer and filter SHALL treat the tach level as low immediately after reset; a tach already high SHALL NOT produce a pulse.
REQ-027 Reset mid-window SHALL discard the partial count; no o_clr_cnt is emitted for the discarded window.

Configuration
REQ-028 Macro FAN_TACH_GLITCH_FILTER_EN defined: the qualified level changes only after the synchronized input differs from it for FILTER_LEN consecutive cycles; o_tach_pulse asserts FILTER_LEN+3 cycles after i_tach is first sampled high.
REQ-029 Macro FAN_TACH_GLITCH_FILTER_EN undefined: the qualified level is the synchronized input; o_tach_pulse asserts 3 cycles after i_tach is first sampled high; FILTER_LEN is ignored.

Structure
REQ-030 The shared package fan_ctrl_pkg SHALL hold the default parameter constants and the filter-length width function.
REQ-031 The synchronizer, filter and edge detect SHALL form the sub-module fan_tach_filter; window, accumulator, capture and stall logic SHALL be in the top level.

Verification
REQ-032 With WINDOW_TICKS=4, i_tick every 10 cycles and tach period 8 cycles at 50% duty: each window SHALL capture 5, with o_clr_cnt every 40 cycles.
REQ-033 With FAN_TACH_GLITCH_FILTER_EN and FILTER_LEN=4: a 2-cycle high glitch -> no pulse; a 6-cycle high -> exactly 1 pulse, 7 cycles after the rise.
REQ-034 With CNT_WIDTH=4 and 20 edges in one window: o_tach_cnt=15.
REQ-035 With STALL_WINDOWS=2 and tach held low: o_fan_stall SHALL rise at the second capture and fall on the first window capturing 3 edges.
REQ-036 Pulse coincident with the closing i_tick: it SHALL be counted in the closing window, and the next window SHALL start from 0.
REQ-037 Reset asserted for 1 cycle mid-window: all outputs SHALL read 0, and the next o_clr_cnt SHALL come WINDOW_TICKS ticks after reset release.
